rot_issue: RTL

Issue and result stage for the fixed-point rotate/shift instructions (rlwinm, rlwimi, rlwnm, slw, srw, sraw, srawi). It accepts decoded operations through a valid/ready handshake and translates each into rotate amount, mask bounds and insert word for the combinational rotate-and-mask unit. It applies the out-of-range shift overrides, recomputes CR0, and registers the result toward writeback, also under valid/ready.

---
 rtl/rot_issue_pkg.sv | 33 +++
 rtl/rot_issue_rotm.sv | 27 ++
 rtl/rot_issue.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/rot_issue_pkg.sv
// Shared types for the rotate/shift issue stage: op encoding, result record, CR0 helper.
package rot_issue_pkg;

  localparam int unsigned DWIDTH = 32;

  typedef enum logic [2:0] {
    RLWINM = 3'd0,
    RLWIMI = 3'd1,
    RLWNM  = 3'd2,
    SLW    = 3'd3,
    SRW    = 3'd4,
    SRAW   = 3'd5,
    SRAWI  = 3'd6
  } Rot_op;

  typedef struct packed {
    logic [DWIDTH-1:0] res;
    logic [4:0]        tag;
    logic [3:0]        cr;
    logic              cr_we;
    logic              ca;
    logic              ca_we;
  } Rot_result;

  // CR0 as {lt, gt, eq, so}; so is never set by this unit.
  function automatic logic [3:0] calc_cr0(input logic [DWIDTH-1:0] r);
    logic lt, eq;
    lt = r[DWIDTH-1];
    eq = !lt && (r == '0);
    return {lt, !lt && !eq, eq, 1'b0};
  endfunction

endpackage

// File: rtl/rot_issue_rotm.sv
// Combinational rotate-and-mask unit: rotl(rs, sh) merged with ins under mask mstart..mstop
// (PowerISA bit numbering, wrapping when mstart > mstop).
module rot_issue_rotm
  import rot_issue_pkg::*;
(
  input  logic [DWIDTH-1:0] rs,
  input  logic [DWIDTH-1:0] ins,
  input  logic [4:0]        sh,
  input  logic [4:0]        mstart,
  input  logic [4:0]        mstop,
  output logic [DWIDTH-1:0] res,
  output logic              ca
);

  logic [DWIDTH-1:0] rot, m_hi, m_lo, mask;

  always_comb begin
    rot  = (rs << sh) | (rs >> (6'd32 - {1'b0, sh}));
    // PowerISA bit i maps to vector bit 31-i.
    m_hi = {DWIDTH{1'b1}} >> mstart;
    m_lo = {DWIDTH{1'b1}} << (5'd31 - mstop);
    mask = (mstart <= mstop) ? (m_hi & m_lo) : (m_hi | m_lo);
    res  = (rot & mask) | (ins & ~mask);
    ca   = rs[DWIDTH-1] & (|(rot & ~mask));
  end

endmodule

// File: rtl/rot_issue.sv
// Issue/result stage for rlwinm/rlwimi/rlwnm/slw/srw/sraw/srawi.
// Define ROT_ISSUE_SKID_EN for a 2-entry output buffer; otherwise a single output register.
module rot_issue
  import rot_issue_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [DWIDTH-1:0] in_rs,
  input  logic [DWIDTH-1:0] in_ra,
  input  logic [DWIDTH-1:0] in_rb,
  input  logic [4:0]        in_sh,
  input  logic [4:0]        in_mb,
  input  logic [4:0]        in_me,
  input  logic              in_rc,
  input  logic [4:0]        in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_res,
  output logic [4:0]        out_tag,
  output logic [3:0]        out_cr,
  output logic              out_cr_we,
  output logic              out_ca,
  output logic              out_ca_we
);

  Rot_op             op;
  logic [4:0]        n, rot_sh, mstart, mstop;
  logic              big, is_sra;
  logic [DWIDTH-1:0] ins, rot_res, fin_res;
  logic              rot_ca, fin_ca;
  Rot_result         nxt, head;
  logic              unused_rb;

  assign op        = Rot_op'(in_op);
  assign unused_rb = ^in_rb[DWIDTH-1:6];

  always_comb begin
    n      = (op == SRAWI) ? in_sh : in_rb[4:0];
    is_sra = (op == SRAW) || (op == SRAWI);
    big    = 1'b0;
    rot_sh = in_sh;
    mstart = in_mb;
    mstop  = in_me;
    ins    = '0;
    case (op)
      RLWIMI: ins = in_ra;
      RLWNM:  rot_sh = n;
      SLW: begin
        rot_sh = n;
        mstart = '0;
        mstop  = 5'd31 - n;
        big    = in_rb[5];
      end
      SRW, SRAW, SRAWI: begin
        rot_sh = 5'd0 - n;
        mstart = n;
        mstop  = 5'd31;
        big    = in_rb[5] && (op != SRAWI);
        if (op != SRW) ins = {DWIDTH{in_rs[DWIDTH-1]}};
      end
      default: ;
    endcase
  end

  rot_issue_rotm u_rotm (
    .rs     (in_rs),
    .ins    (ins),
    .sh     (rot_sh),
    .mstart (mstart),
    .mstop  (mstop),
    .res    (rot_res),
    .ca     (rot_ca)
  );

  // Shift amounts of 32..63 replace the rotate unit's result outright.
  always_comb begin
    fin_res = rot_res;
    fin_ca  = is_sra && rot_ca;
    if (big) begin
      if (op == SRAW) begin
        fin_res = {DWIDTH{in_rs[DWIDTH-1]}};
        fin_ca  = in_rs[DWIDTH-1];
      end else begin
        fin_res = '0;
      end
    end
    nxt = '{res: fin_res, tag: in_tag, cr: calc_cr0(fin_res),
            cr_we: in_rc, ca: fin_ca, ca_we: is_sra};
  end

`ifdef ROT_ISSUE_SKID_EN
  Rot_result  q0, q1;
  logic [1:0] count, count_nxt;
  logic       in_ready_r, push, pop;

  assign push = in_valid && in_ready_r;
  assign pop  = (count != 2'd0) && out_ready;

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 2'd1;
    else if (pop && !push) count_nxt = count - 2'd1;
  end

  // q0 is always the head; q1 only fills when the head is stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q0         <= '0;
      q1         <= '0;
      count      <= '0;
      in_ready_r <= 1'b1;
    end else begin
      count      <= count_nxt;
      in_ready_r <= (count_nxt < 2'd2);
      case (count)
        2'd0: if (push) q0 <= nxt;
        2'd1: begin
          if (push && pop) q0 <= nxt;
          else if (push)   q1 <= nxt;
        end
        default: if (pop) q0 <= q1;
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = (count != 2'd0);
  assign head      = q0;
`else
  Rot_result q;
  logic      valid_r;

  assign in_ready = !valid_r || out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q       <= '0;
      valid_r <= 1'b0;
    end else if (in_ready) begin
      valid_r <= in_valid;
      if (in_valid) q <= nxt;
    end
  end

  assign out_valid = valid_r;
  assign head      = q;
`endif

  assign out_res   = head.res;
  assign out_tag   = head.tag;
  assign out_cr    = head.cr;
  assign out_cr_we = head.cr_we;
  assign out_ca    = head.ca;
  assign out_ca_we = head.ca_we;

endmodule
